lvt_mem_arbiter: RTL and testbench
==================================

# lvt_mem_arbiter

Round-robin arbiter that shares the 2-write/1-read LVT-based multi-port memory among NUM_REQ requesters. Each cycle it grants at most two writes, one to each memory write port, and one read. It resolves same-address hazards and tags read responses with the requester ID. It sits between the client request buses and the memory's wr0/wr1/rd0 ports.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_WIDTH, 7: memory address width.
- DATA_WIDTH, 5: memory data width.
- RD_LAT, 1: memory read latency in cycles from the rd0_en edge to valid rd0_data (1..4).
- ID_W, $clog2(NUM_REQ): requester ID width.

Ports:
- clk  in  1  clock; all state is on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  request address; requester i uses slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data; requester i uses slice i.
- req_ready  out  NUM_REQ  grant; the request is accepted on the edge where valid and ready are both 1.
- wr0_en, wr1_en  out  1  memory write enables.
- wr0_addr, wr1_addr  out  ADDR_WIDTH  memory write addresses.
- wr0_data, wr1_data  out  DATA_WIDTH  memory write data.
- rd0_en  out  1  memory read enable.
- rd0_addr  out  ADDR_WIDTH  memory read address.
- rd0_data  in  DATA_WIDTH  memory read data.
- rsp_valid  out  1  read response valid.
- rsp_id  out  ID_W  ID of the requester that owns the response.
- rsp_data  out  DATA_WIDTH  read data; equals rd0_data.
- conflict_cnt  out  16  saturating count of hazard deferrals.

## Operation
- **State:**
  - wr_ptr and rd_ptr, each ID_W bits.
  - Response pipeline of RD_LAT stages, each stage holding {valid, id}.
  - conflict_cnt.
- **Write arbitration (combinational each cycle):**
  - Scan requesters from wr_ptr upward, modulo NUM_REQ.
  - The first with valid & we is granted onto port 0.
  - The next with valid & we and an address different from port 0's is granted onto port 1.
  - A write whose address equals port 0's is not granted this cycle.
  - Port 0 always carries the earlier requester in scan order.
- **Read arbitration:**
  - Scan from rd_ptr upward for the first requester with valid & !we.
  - It is granted only if its address matches neither granted write address.
  - On a match, no read is granted that cycle (rd0_en=0) and the read is retried next cycle. Read-after-write therefore returns the new data.
  - No other reader is substituted in a deferral cycle.
- **Pointer updates:**
  - On any write grant, wr_ptr <= (last granted write ID + 1) mod NUM_REQ.
  - On a read grant, rd_ptr <= (granted read ID + 1) mod NUM_REQ.
  - A pointer is unchanged when there is no grant of its kind.
- **conflict_cnt:** increments by 1 per cycle in which a write same-address skip or a read deferral occurs (either or both count once). Saturates at 0xFFFF.
- **req_ready[i]:** 1 iff requester i is granted this cycle. Each requester carries a single request, so it receives at most one grant.
- **Ungranted ports** drive en=0, addr=0, data=0.
- **Responses:**
  - A read grant pushes {1, id} into stage 0.
  - The pipeline shifts every cycle.
  - rsp_valid and rsp_id come from the last stage.
  - Responses are returned in grant order and are never stalled; requesters must always accept them.
- **Reset:**
  - req_ready=0, all memory enables 0, rsp_valid=0, rsp_id=0.
  - Pointers and conflict_cnt are 0.
  - Pipeline is cleared. In-flight reads are dropped with no response, and writes in the reset cycle are not issued.

## Timing
- Grants and memory port signals are combinational from the requests of the same cycle. The write takes effect at the acceptance edge.
- Read accepted at edge T: rsp_valid=1 in the cycle following edge T+RD_LAT-1, aligned with rd0_data. With RD_LAT=1, the response appears in the cycle right after acceptance.
- Sustained throughput is 2 writes + 1 read per cycle with no bubbles unless a hazard occurs.
- Deferred read: accepted one or more cycles later, and the latency is counted from actual acceptance.

## Test plan
- **Reset state:** rst pulse with all req_valid=1 -> all outputs 0 during reset; pointers start at 0 afterwards.
- **Two writes, distinct addresses:** requesters 0 and 1 write addr 5 and addr 9 -> wr0 = (5, req0 data), wr1 = (9, req1 data), req_ready=0011, wr_ptr=2.
- **Round-robin fairness:** all 4 requesters write continuously to distinct addresses -> grant pairs {0,1},{2,3},{0,1}…; no requester waits more than 1 cycle.
- **Same-address writes:** requesters 2 and 3 both write addr 7 with wr_ptr=2 -> only req 2 on wr0 in cycle 1; req 3 on wr0 the next cycle; conflict_cnt=1.
- **Read-after-write hazard:** req 0 writes addr 3 = 5'h1A while req 1 reads addr 3 in the same cycle -> read deferred one cycle, conflict_cnt increments. Response has rsp_id=1 and rsp_data=5'h1A, arriving RD_LAT cycles after the deferred acceptance.
- **Reset mid-read:** with RD_LAT=3, assert rst 1 cycle after a read grant -> no rsp_valid after reset deasserts.

Source files
------------

// File: rtl/lvt_mem_arbiter.sv
// Round-robin arbiter sharing a 2-write/1-read LVT memory among NUM_REQ clients.
// Grants are combinational; read responses are tagged through an RD_LAT pipeline.
module lvt_mem_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 5,
   parameter int RD_LAT     = 1,
   parameter int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       wr0_en,
   output logic [ADDR_WIDTH-1:0]      wr0_addr,
   output logic [DATA_WIDTH-1:0]      wr0_data,
   output logic                       wr1_en,
   output logic [ADDR_WIDTH-1:0]      wr1_addr,
   output logic [DATA_WIDTH-1:0]      wr1_data,
   output logic                       rd0_en,
   output logic [ADDR_WIDTH-1:0]      rd0_addr,
   input  logic [DATA_WIDTH-1:0]      rd0_data,
   output logic                       rsp_valid,
   output logic [ID_W-1:0]            rsp_id,
   output logic [DATA_WIDTH-1:0]      rsp_data,
   output logic [15:0]                conflict_cnt
);

   logic [ID_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [ID_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [RD_LAT-1:0]     pv_q;
   logic [ID_W-1:0]       pid_q [RD_LAT];
   logic [15:0]           cnt_q;

   logic                  w0_found, w1_found, r_found, r_grant;
   logic                  w_skip, r_defer;
   logic [ID_W-1:0]       w0_id, w1_id, r_id;
   logic [ADDR_WIDTH-1:0] a0, a1, ra;
   logic [DATA_WIDTH-1:0] d0, d1;

   always_comb begin
      int idx;
      idx      = 0;
      w0_found = 1'b0;
      w1_found = 1'b0;
      r_found  = 1'b0;
      r_grant  = 1'b0;
      w_skip   = 1'b0;
      r_defer  = 1'b0;
      w0_id    = '0;
      w1_id    = '0;
      r_id     = '0;
      a0       = '0;
      a1       = '0;
      ra       = '0;
      d0       = '0;
      d1       = '0;
      req_ready = '0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (!rst) begin
         // Port 1 only takes writes whose address differs from port 0's
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(wr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx] && req_we[idx] && !w1_found) begin
               if (!w0_found) begin
                  w0_found = 1'b1;
                  w0_id    = ID_W'(idx);
                  a0       = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                  d0       = req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
               end else if (req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH] != a0) begin
                  w1_found = 1'b1;
                  w1_id    = ID_W'(idx);
                  a1       = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
                  d1       = req_wdata[idx*DATA_WIDTH +: DATA_WIDTH];
               end else begin
                  w_skip = 1'b1;
               end
            end
         end
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rd_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx] && !req_we[idx] && !r_found) begin
               r_found = 1'b1;
               r_id    = ID_W'(idx);
               ra      = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
            end
         end
         // A read hitting a same-cycle write waits so it sees the new data
         r_defer = r_found &&
                   ((w0_found && ra == a0) || (w1_found && ra == a1));
         r_grant = r_found && !r_defer;
         if (w0_found) req_ready[w0_id] = 1'b1;
         if (w1_found) req_ready[w1_id] = 1'b1;
         if (r_grant)  req_ready[r_id]  = 1'b1;
         if (w1_found) begin
            wr_ptr_d = (w1_id == ID_W'(NUM_REQ-1)) ? '0 : w1_id + 1'b1;
         end else if (w0_found) begin
            wr_ptr_d = (w0_id == ID_W'(NUM_REQ-1)) ? '0 : w0_id + 1'b1;
         end
         if (r_grant) begin
            rd_ptr_d = (r_id == ID_W'(NUM_REQ-1)) ? '0 : r_id + 1'b1;
         end
      end
   end

   assign wr0_en   = w0_found;
   assign wr0_addr = a0;
   assign wr0_data = d0;
   assign wr1_en   = w1_found;
   assign wr1_addr = a1;
   assign wr1_data = d1;
   assign rd0_en   = r_grant;
   assign rd0_addr = r_grant ? ra : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         pv_q     <= '0;
         for (int s = 0; s < RD_LAT; s++) pid_q[s] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if ((w_skip || r_defer) && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
         end
         for (int s = RD_LAT - 1; s > 0; s--) begin
            pv_q[s]  <= pv_q[s-1];
            pid_q[s] <= pid_q[s-1];
         end
         pv_q[0]  <= r_grant;
         pid_q[0] <= r_grant ? r_id : '0;
      end
   end

   assign rsp_valid    = pv_q[RD_LAT-1];
   assign rsp_id       = pid_q[RD_LAT-1];
   assign rsp_data     = rd0_data;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_lvt_mem_arbiter.sv
// Directed bench for lvt_mem_arbiter: RD_LAT=1 instance with a memory model,
// plus an RD_LAT=3 instance for the reset-during-read scenario.
module tb_lvt_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst, rst2;
   logic [3:0]  req_valid, req_we;
   logic [27:0] req_addr;
   logic [19:0] req_wdata;

   logic [3:0]  ready;
   logic        w0e, w1e, rde, rspv;
   logic [6:0]  w0a, w1a, rda;
   logic [4:0]  w0d, w1d, rdd, rspd;
   logic [1:0]  rspid;
   logic [15:0] ccnt;

   logic [3:0]  ready2;
   logic        w0e2, w1e2, rde2, rspv2;
   logic [6:0]  w0a2, w1a2, rda2;
   logic [4:0]  w0d2, w1d2, rspd2;
   logic [1:0]  rspid2;
   logic [15:0] ccnt2;

   logic [4:0]  mem [128];
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (w0e) mem[w0a] <= w0d;
      if (w1e) mem[w1a] <= w1d;
      if (rde) rdd <= mem[rda];
   end

   lvt_mem_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(7), .DATA_WIDTH(5), .RD_LAT(1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready),
      .wr0_en(w0e), .wr0_addr(w0a), .wr0_data(w0d),
      .wr1_en(w1e), .wr1_addr(w1a), .wr1_data(w1d),
      .rd0_en(rde), .rd0_addr(rda), .rd0_data(rdd),
      .rsp_valid(rspv), .rsp_id(rspid), .rsp_data(rspd), .conflict_cnt(ccnt)
   );

   lvt_mem_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(7), .DATA_WIDTH(5), .RD_LAT(3)) dut2 (
      .clk(clk), .rst(rst2), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready2),
      .wr0_en(w0e2), .wr0_addr(w0a2), .wr0_data(w0d2),
      .wr1_en(w1e2), .wr1_addr(w1a2), .wr1_data(w1d2),
      .rd0_en(rde2), .rd0_addr(rda2), .rd0_data(5'h00),
      .rsp_valid(rspv2), .rsp_id(rspid2), .rsp_data(rspd2), .conflict_cnt(ccnt2)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clr;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   task automatic put(input int i, input logic we,
                      input logic [6:0] a, input logic [4:0] d);
      req_valid[i]       = 1'b1;
      req_we[i]          = we;
      req_addr[i*7 +: 7] = a;
      req_wdata[i*5 +: 5] = d;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      clr();
      for (int i = 0; i < 4; i++) put(i, 1'b1, 7'(40 + i), 5'(i + 1));
      #3;
      n_cmp++; if (ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready: got %b want 0000", ready); end
      n_cmp++; if ({w0e, w1e, rde} !== 3'b000) begin n_bad++; $display("FAIL rst_en: got %b want 000", {w0e, w1e, rde}); end
      n_cmp++; if ({w0a, w0d, w1a, w1d, rda} !== 31'd0) begin n_bad++; $display("FAIL rst_ports: got %h want 0", {w0a, w0d, w1a, w1d, rda}); end
      n_cmp++; if ({rspv, rspid, ccnt} !== 19'd0) begin n_bad++; $display("FAIL rst_rsp: got %h want 0", {rspv, rspid, ccnt}); end
      tick();
      n_cmp++; if ({ready, w0e, w1e} !== 6'd0) begin n_bad++; $display("FAIL rst_edge: got %h want 0", {ready, w0e, w1e}); end
      clr();
      rst = 1'b0;
   endtask

   task automatic test_two_writes;
      clr();
      put(0, 1'b1, 7'd5, 5'h11);
      put(1, 1'b1, 7'd9, 5'h0C);
      #1;
      n_cmp++; if (ready !== 4'b0011) begin n_bad++; $display("FAIL tw_ready: got %b want 0011", ready); end
      n_cmp++; if ({w0e, w0a, w0d} !== {1'b1, 7'd5, 5'h11}) begin n_bad++; $display("FAIL tw_wr0: got %b/%0d/%h want 1/5/11", w0e, w0a, w0d); end
      n_cmp++; if ({w1e, w1a, w1d} !== {1'b1, 7'd9, 5'h0C}) begin n_bad++; $display("FAIL tw_wr1: got %b/%0d/%h want 1/9/0c", w1e, w1a, w1d); end
      n_cmp++; if (rde !== 1'b0) begin n_bad++; $display("FAIL tw_rd: got %b want 0", rde); end
      tick();
   endtask

   task automatic test_round_robin;
      logic [3:0] exp [4];
      exp[0] = 4'b1100; exp[1] = 4'b0011; exp[2] = 4'b1100; exp[3] = 4'b0011;
      clr();
      for (int i = 0; i < 4; i++) put(i, 1'b1, 7'(60 + i), 5'(i + 8));
      for (int c = 0; c < 4; c++) begin
         #1;
         n_cmp++; if (ready !== exp[c]) begin n_bad++; $display("FAIL rr_ready%0d: got %b want %b", c, ready, exp[c]); end
         n_cmp++; if (w0a !== ((c % 2 == 0) ? 7'd62 : 7'd60)) begin n_bad++; $display("FAIL rr_wr0addr%0d: got %0d", c, w0a); end
         tick();
      end
   endtask

   task automatic test_same_addr;
      clr();
      put(2, 1'b1, 7'd7, 5'h0A);
      put(3, 1'b1, 7'd7, 5'h0B);
      #1;
      n_cmp++; if (ready !== 4'b0100) begin n_bad++; $display("FAIL sa_ready1: got %b want 0100", ready); end
      n_cmp++; if ({w0e, w0a, w0d} !== {1'b1, 7'd7, 5'h0A}) begin n_bad++; $display("FAIL sa_wr0_1: got %b/%0d/%h want 1/7/0a", w0e, w0a, w0d); end
      n_cmp++; if ({w1e, w1a, w1d} !== 13'd0) begin n_bad++; $display("FAIL sa_wr1: got %b/%0d/%h want 0/0/0", w1e, w1a, w1d); end
      tick();
      n_cmp++; if (ccnt !== 16'd1) begin n_bad++; $display("FAIL sa_cnt1: got %0d want 1", ccnt); end
      req_valid[2] = 1'b0;
      #1;
      n_cmp++; if (ready !== 4'b1000) begin n_bad++; $display("FAIL sa_ready2: got %b want 1000", ready); end
      n_cmp++; if ({w0e, w0a, w0d} !== {1'b1, 7'd7, 5'h0B}) begin n_bad++; $display("FAIL sa_wr0_2: got %b/%0d/%h want 1/7/0b", w0e, w0a, w0d); end
      tick();
      n_cmp++; if (ccnt !== 16'd1) begin n_bad++; $display("FAIL sa_cnt2: got %0d want 1", ccnt); end
   endtask

   task automatic test_raw;
      clr();
      put(0, 1'b1, 7'd3, 5'h1A);
      put(1, 1'b0, 7'd3, 5'h00);
      #1;
      n_cmp++; if (ready !== 4'b0001) begin n_bad++; $display("FAIL raw_ready1: got %b want 0001", ready); end
      n_cmp++; if ({rde, rda} !== 8'd0) begin n_bad++; $display("FAIL raw_defer: got %b/%0d want 0/0", rde, rda); end
      tick();
      n_cmp++; if (ccnt !== 16'd2) begin n_bad++; $display("FAIL raw_cnt: got %0d want 2", ccnt); end
      n_cmp++; if (rspv !== 1'b0) begin n_bad++; $display("FAIL raw_norsp: got %b want 0", rspv); end
      req_valid[0] = 1'b0;
      #1;
      n_cmp++; if ({ready, rde, rda} !== {4'b0010, 1'b1, 7'd3}) begin n_bad++; $display("FAIL raw_grant: got %b/%b/%0d want 0010/1/3", ready, rde, rda); end
      tick();
      n_cmp++; if ({rspv, rspid, rspd} !== {1'b1, 2'd1, 5'h1A}) begin n_bad++; $display("FAIL raw_rsp: got %b/%0d/%h want 1/1/1a", rspv, rspid, rspd); end
      clr();
      tick();
      n_cmp++; if (rspv !== 1'b0) begin n_bad++; $display("FAIL raw_rspend: got %b want 0", rspv); end
   endtask

   task automatic test_back_to_back;
      clr();
      put(1, 1'b1, 7'd20, 5'h03);
      put(3, 1'b1, 7'd21, 5'h04);
      put(0, 1'b0, 7'd9, 5'h00);
      #1;
      n_cmp++; if (ready !== 4'b1011) begin n_bad++; $display("FAIL bb_ready: got %b want 1011", ready); end
      n_cmp++; if ({w0a, w1a, rda} !== {7'd20, 7'd21, 7'd9}) begin n_bad++; $display("FAIL bb_addrs: got %0d/%0d/%0d want 20/21/9", w0a, w1a, rda); end
      tick();
      n_cmp++; if ({rspv, rspid, rspd} !== {1'b1, 2'd0, 5'h0C}) begin n_bad++; $display("FAIL bb_rsp: got %b/%0d/%h want 1/0/0c", rspv, rspid, rspd); end
      clr();
      put(0, 1'b1, 7'd30, 5'h15);
      put(1, 1'b1, 7'd31, 5'h0A);
      put(2, 1'b0, 7'd31, 5'h00);
      #1;
      n_cmp++; if ({ready, rde} !== {4'b0011, 1'b0}) begin n_bad++; $display("FAIL bb_defer1: got %b/%b want 0011/0", ready, rde); end
      tick();
      n_cmp++; if (ccnt !== 16'd3) begin n_bad++; $display("FAIL bb_cnt: got %0d want 3", ccnt); end
      req_valid[1:0] = 2'b00;
      #1;
      n_cmp++; if ({ready, rde, rda} !== {4'b0100, 1'b1, 7'd31}) begin n_bad++; $display("FAIL bb_grant: got %b/%b/%0d want 0100/1/31", ready, rde, rda); end
      tick();
      n_cmp++; if ({rspv, rspid, rspd} !== {1'b1, 2'd2, 5'h0A}) begin n_bad++; $display("FAIL bb_rsp2: got %b/%0d/%h want 1/2/0a", rspv, rspid, rspd); end
      clr();
      tick();
   endtask

   task automatic test_reset_mid_read;
      clr();
      rst2 = 1'b0;
      put(0, 1'b0, 7'd1, 5'h00);
      #1;
      n_cmp++; if ({ready2, rde2} !== {4'b0001, 1'b1}) begin n_bad++; $display("FAIL l3_grant: got %b/%b want 0001/1", ready2, rde2); end
      tick();
      clr();
      for (int c = 0; c < 2; c++) begin
         n_cmp++; if (rspv2 !== 1'b0) begin n_bad++; $display("FAIL l3_early%0d: got %b want 0", c, rspv2); end
         tick();
      end
      n_cmp++; if ({rspv2, rspid2} !== {1'b1, 2'd0}) begin n_bad++; $display("FAIL l3_rsp: got %b/%0d want 1/0", rspv2, rspid2); end
      tick();
      n_cmp++; if (rspv2 !== 1'b0) begin n_bad++; $display("FAIL l3_rspend: got %b want 0", rspv2); end
      put(1, 1'b0, 7'd2, 5'h00);
      #1;
      n_cmp++; if (ready2 !== 4'b0010) begin n_bad++; $display("FAIL l3_grant2: got %b want 0010", ready2); end
      tick();
      clr();
      tick();
      rst2 = 1'b1;
      #1;
      n_cmp++; if (rspv2 !== 1'b0) begin n_bad++; $display("FAIL l3_inrst: got %b want 0", rspv2); end
      tick();
      tick();
      rst2 = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_cmp++; if (rspv2 !== 1'b0) begin n_bad++; $display("FAIL l3_dropped%0d: got %b want 0", c, rspv2); end
      end
   endtask

   initial begin
      rst2 = 1'b1;
      test_reset();
      test_two_writes();
      test_round_robin();
      test_same_addr();
      test_raw();
      test_back_to_back();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
